// File: rtl/xadc_pkg.sv
// Shared definitions for the XADC scan controller: FSM encoding, PDO channel
// codes and the averaging limit.
package xadc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ACC   = 3'd4,
        ST_STORE = 3'd5,
        ST_TOUT  = 3'd6
    } xadc_state_e;

    localparam int unsigned AVG_LOG2_MAX = 4;
    localparam int unsigned PDO_CHANNELS = 8;

    localparam logic [4:0] CH_PDO0 = 5'b00000;
    localparam logic [4:0] CH_PDO1 = 5'b00001;
    localparam logic [4:0] CH_PDO2 = 5'b00010;
    localparam logic [4:0] CH_PDO3 = 5'b00011;
    localparam logic [4:0] CH_PDO4 = 5'b00100;
    localparam logic [4:0] CH_PDO5 = 5'b00101;
    localparam logic [4:0] CH_PDO6 = 5'b00110;
    localparam logic [4:0] CH_PDO7 = 5'b00111;

    function automatic logic [4:0] pdo_ch_sel(input logic [2:0] idx);
        case (idx)
            3'd0:    return CH_PDO0;
            3'd1:    return CH_PDO1;
            3'd2:    return CH_PDO2;
            3'd3:    return CH_PDO3;
            3'd4:    return CH_PDO4;
            3'd5:    return CH_PDO5;
            3'd6:    return CH_PDO6;
            default: return CH_PDO7;
        endcase
    endfunction

    function automatic logic [2:0] clamp_log2(input logic [2:0] v);
        return (v > 3'(AVG_LOG2_MAX)) ? 3'(AVG_LOG2_MAX) : v;
    endfunction

endpackage

// File: rtl/xadc_avg_acc.sv
// Sample accumulator for one averaged measurement: running 16-bit sum,
// sample counter and the final power-of-two divide.
module xadc_avg_acc
    import xadc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        add_i,
    input  logic [11:0] sample_i,
    input  logic        inc_i,
    input  logic [2:0]  log2_i,
    output logic        last_o,
    output logic [11:0] avg_o
);

    localparam int CNT_W = AVG_LOG2_MAX + 1;

    logic [15:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else begin
            if (add_i) acc_d = acc_q + 16'(sample_i);
            if (inc_i) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // Evaluated while the counter still holds the pre-increment value.
    assign last_o = (cnt_q + CNT_W'(1)) == (CNT_W'(1) << log2_i);
    assign avg_o  = 12'(acc_q >> log2_i);

endmodule

// File: rtl/xadc_scan_ctrl.sv
// XADC measurement sequencer: periodic background sweep of PDO0..7 into a
// readable table, interleaved with averaged host measurements, with watchdog.
module xadc_scan_ctrl
    import xadc_pkg::*;
#(
    parameter int unsigned SCAN_PERIOD = 125000,
    parameter int unsigned TIMEOUT     = 65535
) (
    input  logic        clk125,
    input  logic        rst,
    input  logic        scan_en,
    input  logic        host_req,
    input  logic [4:0]  host_ch,
    input  logic [2:0]  avg_log2,
    output logic        eng_start,
    output logic [4:0]  eng_ch_sel,
    input  logic        eng_done,
    input  logic [11:0] eng_result,
    output logic        host_ack,
    output logic [11:0] host_result,
    output logic        host_err,
    input  logic [2:0]  rd_addr,
    output logic [12:0] rd_data,
    output logic        busy,
    output logic [7:0]  timeout_cnt,
    output xadc_state_e state_dbg
);

    localparam int PER_W = $clog2(SCAN_PERIOD + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SCAN_PERIOD - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT);

    xadc_state_e      state_q;
    logic [PER_W-1:0] per_q;
    logic             pend_q;
    logic [2:0]       idx_q;
    logic             is_host_q;
    logic [4:0]       ch_q;
    logic [2:0]       n_q;
    logic [WD_W-1:0]  wd_q;
    logic             start_q;
    logic             ack_q;
    logic             err_q;
    logic [11:0]      result_q;
    logic [7:0]       tcnt_q;
    logic [12:0]      tbl_q [PDO_CHANNELS];

    logic        acc_last;
    logic [11:0] acc_avg;

    xadc_avg_acc u_acc (
        .clk_i    (clk125),
        .rst_i    (rst),
        .clr_i    (state_q == ST_ARB),
        .add_i    ((state_q == ST_WAIT) && eng_done),
        .sample_i (eng_result),
        .inc_i    (state_q == ST_ACC),
        .log2_i   (n_q),
        .last_o   (acc_last),
        .avg_o    (acc_avg)
    );

    always_ff @(posedge clk125) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            per_q     <= '0;
            pend_q    <= 1'b0;
            idx_q     <= '0;
            is_host_q <= 1'b0;
            ch_q      <= '0;
            n_q       <= '0;
            wd_q      <= '0;
            start_q   <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            result_q  <= '0;
            tcnt_q    <= '0;
            for (int i = 0; i < PDO_CHANNELS; i++) tbl_q[i] <= '0;
        end else begin
            start_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!scan_en) idx_q <= '0;
                    if (host_req || (pend_q && scan_en)) state_q <= ST_ARB;
                end
                ST_ARB: begin
                    n_q <= clamp_log2(avg_log2);
                    if (host_req) begin
                        is_host_q <= 1'b1;
                        ch_q      <= host_ch;
                        start_q   <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end else if (pend_q && scan_en) begin
                        is_host_q <= 1'b0;
                        ch_q      <= pdo_ch_sel(idx_q);
                        start_q   <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    wd_q    <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        state_q <= ST_ACC;
                    end else if (wd_q == WD_LAST) begin
                        state_q <= ST_TOUT;
                        if (tcnt_q != 8'hFF) tcnt_q <= tcnt_q + 8'd1;
                        if (is_host_q) begin
                            ack_q    <= 1'b1;
                            err_q    <= 1'b1;
                            result_q <= '0;
                        end else begin
                            tbl_q[idx_q][12] <= 1'b0;
                            idx_q <= scan_en ? idx_q + 3'd1 : 3'd0;
                            if (idx_q == 3'd7) pend_q <= 1'b0;
                        end
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                ST_ACC: begin
                    if (acc_last) begin
                        state_q <= ST_STORE;
                        if (is_host_q) begin
                            ack_q    <= 1'b1;
                            result_q <= acc_avg;
                        end else begin
                            tbl_q[idx_q] <= {1'b1, acc_avg};
                            idx_q <= scan_en ? idx_q + 3'd1 : 3'd0;
                            if (idx_q == 3'd7) pend_q <= 1'b0;
                        end
                    end else begin
                        start_q <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Placed after the FSM so a new period tick wins over the sweep-end clear.
            if (scan_en) begin
                if (per_q == PER_LAST) begin
                    per_q  <= '0;
                    pend_q <= 1'b1;
                end else begin
                    per_q <= per_q + PER_W'(1);
                end
            end else begin
                per_q  <= '0;
                pend_q <= 1'b0;
            end
        end
    end

    assign eng_start   = start_q;
    assign eng_ch_sel  = ch_q;
    assign host_ack    = ack_q;
    assign host_err    = err_q;
    assign host_result = result_q;
    assign timeout_cnt = tcnt_q;
    assign rd_data     = tbl_q[rd_addr];
    assign busy        = (state_q != ST_IDLE);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_xadc_scan_ctrl.sv
// Bench for xadc_scan_ctrl: randomized engine latency and sample values,
// expectations from a behavioural model of averaging, sweeping and timeouts.
module tb_xadc_scan_ctrl;
    import xadc_pkg::*;

    localparam int unsigned SCAN_PERIOD = 200;
    localparam int unsigned TIMEOUT     = 50;

    logic        clk125 = 1'b0;
    logic        rst;
    logic        scan_en;
    logic        host_req;
    logic [4:0]  host_ch;
    logic [2:0]  avg_log2;
    logic        eng_start;
    logic [4:0]  eng_ch_sel;
    logic        eng_done;
    logic [11:0] eng_result;
    logic        host_ack;
    logic [11:0] host_result;
    logic        host_err;
    logic [2:0]  rd_addr;
    logic [12:0] rd_data;
    logic        busy;
    logic [7:0]  timeout_cnt;
    xadc_state_e state_dbg;

    logic        eng_silent   = 1'b0;
    logic        model_done   = 1'b0;
    logic [11:0] model_result = '0;
    logic        stray_done   = 1'b0;
    logic [11:0] stray_result = '0;
    logic [11:0] resp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    assign eng_done   = model_done | stray_done;
    assign eng_result = stray_done ? stray_result : model_result;

    xadc_scan_ctrl #(.SCAN_PERIOD(SCAN_PERIOD), .TIMEOUT(TIMEOUT)) dut (
        .clk125      (clk125),
        .rst         (rst),
        .scan_en     (scan_en),
        .host_req    (host_req),
        .host_ch     (host_ch),
        .avg_log2    (avg_log2),
        .eng_start   (eng_start),
        .eng_ch_sel  (eng_ch_sel),
        .eng_done    (eng_done),
        .eng_result  (eng_result),
        .host_ack    (host_ack),
        .host_result (host_result),
        .host_err    (host_err),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .timeout_cnt (timeout_cnt),
        .state_dbg   (state_dbg)
    );

    always #4 clk125 = ~clk125;

    // Engine: answers each start after 1..5 cycles; queued values first, else 100+channel.
    always begin : engine
        int lat;
        logic [11:0] val;
        @(negedge clk125);
        if (eng_start === 1'b1 && !eng_silent) begin
            if (resp_q.size() > 0) val = resp_q.pop_front();
            else val = 12'(100 + int'(eng_ch_sel));
            lat = $urandom_range(1, 5);
            repeat (lat) @(negedge clk125);
            model_result = val;
            model_done   = 1'b1;
            @(negedge clk125);
            model_done   = 1'b0;
        end
    end

    initial begin
        #600000;
        $display("FAIL global_timeout observed=stuck required=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_host(input logic [4:0] ch, input logic [2:0] lg,
                            output logic [11:0] res, output logic err,
                            output int starts, output int bad_ch, output int lat);
        int t0;
        int acked;
        host_ch  = ch;
        avg_log2 = lg;
        host_req = 1'b1;
        starts = 0; bad_ch = 0; lat = -1; t0 = 0; acked = 0; res = '0; err = 1'b0;
        for (int t = 0; t < 3000 && acked == 0; t++) begin
            @(negedge clk125);
            if (eng_start === 1'b1) begin
                if (starts == 0) t0 = t;
                starts++;
                if (eng_ch_sel !== ch) bad_ch++;
            end
            if (host_ack === 1'b1) begin
                acked    = 1;
                res      = host_result;
                err      = host_err;
                lat      = t - t0;
                host_req = 1'b0;
            end
        end
        host_req = 1'b0;
        check("host_ack_seen", acked, 1);
        @(negedge clk125);
        check("host_ack_one_cycle", host_ack, 0);
    endtask

    initial begin
        logic [11:0] res;
        logic        err;
        int starts, bad, lat, n, cnt, sum, v, bad_err;
        int seq, seq_bad, t0a, t0b, found, got, acked;
        logic [4:0]  seen0, seen1, hch;
        logic [11:0] hv;

        rst = 1'b1; scan_en = 1'b0; host_req = 1'b0; host_ch = '0; avg_log2 = '0; rd_addr = '0;
        repeat (3) @(negedge clk125);
        check("rst_eng_start", eng_start, 0);
        check("rst_host_ack", host_ack, 0);
        check("rst_host_err", host_err, 0);
        check("rst_busy", busy, 0);
        check("rst_eng_ch_sel", eng_ch_sel, 0);
        check("rst_host_result", host_result, 0);
        check("rst_timeout_cnt", timeout_cnt, 0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            check($sformatf("rst_tbl%0d", i), rd_data, 0);
        end
        @(negedge clk125);
        rst = 1'b0;
        @(negedge clk125);

        // Directed host measurement: (10+20+30+41)/4 = 25.
        resp_q.push_back(12'd10); resp_q.push_back(12'd20);
        resp_q.push_back(12'd30); resp_q.push_back(12'd41);
        run_host(5'b10011, 3'd2, res, err, starts, bad, lat);
        check("dir_result", res, 25);
        check("dir_err", err, 0);
        check("dir_starts", starts, 4);
        check("dir_ch_sel", bad, 0);

        // Random host measurements, including avg_log2 above the clamp.
        for (int r = 0; r < 6; r++) begin
            logic [2:0] lg;
            lg  = 3'($urandom_range(0, 7));
            n   = (int'(lg) > 4) ? 4 : int'(lg);
            cnt = 1 << n;
            sum = 0;
            for (int k = 0; k < cnt; k++) begin
                v = $urandom_range(0, 4095);
                resp_q.push_back(12'(v));
                sum += v;
            end
            hch = 5'($urandom_range(0, 31));
            run_host(hch, lg, res, err, starts, bad, lat);
            check($sformatf("rand%0d_result", r), res, sum / cnt);
            check($sformatf("rand%0d_err", r), err, 0);
            check($sformatf("rand%0d_starts", r), starts, cnt);
            check($sformatf("rand%0d_ch_sel", r), bad, 0);
        end

        // avg_log2=7 clamps to 16 samples.
        for (int k = 0; k < 16; k++) resp_q.push_back(12'd4095);
        run_host(5'd8, 3'd7, res, err, starts, bad, lat);
        check("clamp_result", res, 4095);
        check("clamp_starts", starts, 16);
        check("clamp_err", err, 0);

        // Silent engine: 51 WAIT cycles elapse, the following cycle carries the error ack.
        eng_silent = 1'b1;
        run_host(5'd17, 3'd0, res, err, starts, bad, lat);
        check("tout_err", err, 1);
        check("tout_result", res, 0);
        check("tout_starts", starts, 1);
        check("tout_latency", lat, int'(TIMEOUT) + 2);
        check("tout_cnt_1", timeout_cnt, 1);
        bad_err = 0;
        for (int k = 1; k < 300; k++) begin
            run_host(5'($urandom_range(0, 31)), 3'd0, res, err, starts, bad, lat);
            if (err !== 1'b1 || res !== 12'd0) bad_err++;
        end
        check("tout_all_err", bad_err, 0);
        check("tout_cnt_sat", timeout_cnt, (300 > 255) ? 255 : 300);
        eng_silent = 1'b0;

        // Background sweep: channels 0..7 in order, sweeps 200 cycles apart.
        avg_log2 = 3'd0;
        scan_en  = 1'b1;
        seq = 0; seq_bad = 0; t0a = -1; t0b = -1;
        for (int t = 0; t < 520; t++) begin
            @(negedge clk125);
            if (eng_start === 1'b1) begin
                if (eng_ch_sel !== 5'(seq % 8)) seq_bad++;
                if (seq % 8 == 0) begin
                    if (t0a < 0) t0a = t;
                    else if (t0b < 0) t0b = t;
                end
                seq++;
            end
        end
        check("scan_starts", seq, 16);
        check("scan_order", seq_bad, 0);
        check("scan_period", t0b - t0a, int'(SCAN_PERIOD));
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            check($sformatf("scan_tbl%0d", i), rd_data, (1 << 12) | (100 + i));
        end

        // Host request while channel 3 is converting: host goes after ch3, sweep resumes at ch4.
        found = 0;
        for (int t = 0; t < 400 && found == 0; t++) begin
            @(negedge clk125);
            if (eng_start === 1'b1 && eng_ch_sel === 5'd3) found = 1;
        end
        check("pre_ch3_seen", found, 1);
        @(negedge clk125);
        hch = 5'($urandom_range(8, 31));
        hv  = 12'($urandom_range(0, 4095));
        resp_q.push_back(hv);
        host_ch  = hch;
        host_req = 1'b1;
        got = 0; acked = 0; seen0 = '0; seen1 = '0; res = '0;
        for (int t = 0; t < 300 && (got < 2 || acked == 0); t++) begin
            @(negedge clk125);
            if (host_ack === 1'b1) begin
                acked = 1; res = host_result; host_req = 1'b0;
            end
            if (eng_start === 1'b1) begin
                if (got == 0) seen0 = eng_ch_sel;
                else if (got == 1) seen1 = eng_ch_sel;
                got++;
            end
        end
        host_req = 1'b0;
        check("pre_acked", acked, 1);
        check("pre_result", res, hv);
        check("pre_first_start", seen0, hch);
        check("pre_resume_ch4", seen1, 4);

        // scan_en drops during ch5: it completes, sweep stops, restart begins at ch0.
        found = 0;
        for (int t = 0; t < 200 && found == 0; t++) begin
            @(negedge clk125);
            if (eng_start === 1'b1 && eng_ch_sel === 5'd5) found = 1;
        end
        check("fall_ch5_seen", found, 1);
        scan_en = 1'b0;
        found = 0;
        for (int t = 0; t < 100 && found == 0; t++) begin
            @(negedge clk125);
            if (busy === 1'b0) found = 1;
        end
        check("fall_idle", found, 1);
        starts = 0;
        for (int t = 0; t < 250; t++) begin
            @(negedge clk125);
            if (eng_start === 1'b1) starts++;
        end
        check("fall_no_starts", starts, 0);
        rd_addr = 3'd5;
        #1;
        check("fall_tbl5", rd_data, (1 << 12) | 105);
        scan_en = 1'b1;
        found = 0; seen0 = 5'h1F;
        for (int t = 0; t < 300 && found == 0; t++) begin
            @(negedge clk125);
            if (eng_start === 1'b1) begin found = 1; seen0 = eng_ch_sel; end
        end
        check("restart_seen", found, 1);
        check("restart_ch0", seen0, 0);
        scan_en = 1'b0;
        found = 0;
        for (int t = 0; t < 100 && found == 0; t++) begin
            @(negedge clk125);
            if (busy === 1'b0) found = 1;
        end
        check("restart_idle", found, 1);

        // Reset during WAIT, then a stray eng_done.
        eng_silent = 1'b1;
        host_ch  = 5'd9;
        avg_log2 = 3'd0;
        host_req = 1'b1;
        found = 0;
        for (int t = 0; t < 50 && found == 0; t++) begin
            @(negedge clk125);
            if (eng_start === 1'b1) found = 1;
        end
        check("rstw_start_seen", found, 1);
        repeat (3) @(negedge clk125);
        rst = 1'b1; host_req = 1'b0;
        @(negedge clk125);
        rst = 1'b0;
        repeat (2) @(negedge clk125);
        stray_result = 12'hABC;
        stray_done   = 1'b1;
        @(negedge clk125);
        stray_done   = 1'b0;
        acked = 0; starts = 0; bad = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk125);
            if (host_ack === 1'b1) acked++;
            if (eng_start === 1'b1) starts++;
            if (busy !== 1'b0) bad++;
        end
        check("rstw_no_ack", acked, 0);
        check("rstw_no_start", starts, 0);
        check("rstw_idle", bad, 0);
        check("rstw_host_result", host_result, 0);
        check("rstw_host_err", host_err, 0);
        check("rstw_eng_ch_sel", eng_ch_sel, 0);
        check("rstw_timeout_cnt", timeout_cnt, 0);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            check($sformatf("rstw_tbl%0d", i), rd_data, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
